sram_loader: RTL and testbench
==============================

Name: sram_loader

Overview:
- Byte-stream boot loader feeding port a (write port) of the dual-port program SRAM.
- Takes framed bytes from the UART receiver, assembles WIDTH-bit words MSB-first, and issues single-cycle writes with an auto-incrementing address.
- Holds the Forth core in hold for the whole transfer, so images load over serial without resynthesising the memory init file.

Parameters:
- WIDTH, 16, SRAM word width in bits; must be a multiple of 8, max 32.
- DEPTH, 8192, SRAM depth in words.
- ADDR_WIDTH, $clog2(DEPTH), SRAM address width; must be ≤16.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- rst  input  1  asynchronous active-high reset.
- clk_a  input  1  clock, same domain as SRAM port a.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts byte; transfer occurs on rx_valid & rx_ready.
- sram_addr  output  ADDR_WIDTH  port a write address.
- sram_wdata  output  WIDTH  port a write data.
- sram_write_en  output  1  port a write strobe, one cycle per word.
- cpu_hold  output  1  core held while a frame is in progress.
- load_busy  output  1  frame in progress (any state except IDLE).
- load_done  output  1  one-cycle pulse on successful frame completion.
- load_err  output  1  sticky error flag.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE.
  - rx_ready=1; sram_addr=0; sram_wdata=0; sram_write_en=0.
  - cpu_hold=0; load_busy=0; load_done=0; load_err=0.
  - Word counter, byte counter and checksum all 0.
- Frame format:
  - SYNC_BYTE.
  - ADDR_HI, ADDR_LO: start word address; upper bits beyond ADDR_WIDTH ignored.
  - LEN_HI, LEN_LO: word count N, 0..65535.
  - N×(WIDTH/8) data bytes, MSB first.
  - [CSUM] only when the optional feature is enabled.
- States:
  - IDLE: accepted byte == SYNC_BYTE → ADDR; clears load_err and checksum. Any other byte is discarded; remain in IDLE.
  - ADDR: two bytes; load the address register; → LEN.
  - LEN: two bytes; load the word counter. If N==0 → CSUM if enabled, else DONE. Otherwise → DATA.
  - DATA: shift each byte into sram_wdata from the LSB side (first byte ends in the MSBs). After byte WIDTH/8 → WRITE.
  - WRITE: exactly one cycle.
    - sram_write_en=1 with sram_addr/sram_wdata stable; rx_ready=0.
    - Next cycle: address increments modulo DEPTH (DEPTH-1 wraps to 0); word counter decrements.
    - Counter reaching 0 → CSUM/DONE; otherwise → DATA.
  - DONE: one cycle; load_done=1; → IDLE.
- rx_ready is 1 in every state except WRITE. Back-to-back bytes on consecutive cycles are legal.
- Write latency: the word is written in the cycle after its last byte is accepted.
- cpu_hold=1 from the cycle after SYNC is accepted until the cycle DONE is entered (DONE cycle has cpu_hold=0); also 0 in IDLE.
- load_busy=1 in every state except IDLE.
- A SYNC_BYTE value occurring mid-frame is treated as ordinary data; there is no resync.
- Reset mid-frame: immediate return to IDLE, hold released, partial words discarded. Words already written remain in SRAM.
- sram_addr and sram_wdata hold their last values outside WRITE.

Optional Feature:
- Macro: SRAM_LOADER_CSUM_EN.
- Defined:
  - 8-bit running sum of every byte after SYNC (address, length, data).
  - Frame ends with a CSUM byte chosen so that sum + CSUM == 8'h00.
  - Match → DONE.
  - Mismatch → load_err=1, no load_done pulse, → IDLE; cpu_hold drops.
  - Writes already performed are not undone.
- Not defined: no CSUM state, no checksum register; load_err is tied 0.

Test Plan:
- Frame A5 00 10 00 02 12 34 AB CD → writes 16'h1234@0x010 and 16'hABCD@0x011. load_done pulses once; cpu_hold high from after A5 to the DONE cycle.
- Frame at address 0x1FFF, N=2, data 11 11 22 22 → writes 0x1111@0x1FFF, then 0x2222@0x0000 (wrap).
- Garbage bytes 00 FF 5A before A5, then a valid N=1 frame → garbage ignored, exactly one write, load_busy low until A5 is accepted.
- Length 0 (A5 00 00 00 00) → no sram_write_en. With CSUM_EN, a 00 checksum byte then load_done. Without it, load_done one cycle after LEN_LO.
- With CSUM_EN, frame A5 00 20 00 01 00 05, CSUM=DA (correct) → load_done. Same frame with CSUM=DB → load_err=1, no load_done, cpu_hold=0, and the word 0x0005 is still written at 0x020.
- rst asserted after the first data byte → all outputs at reset values immediately. A subsequent full frame loads correctly.

Source files
------------

// File: rtl/sram_loader.sv
// sram_loader: UART byte-stream boot loader writing framed words into SRAM port a (optional checksum: SRAM_LOADER_CSUM_EN)
module sram_loader #(
  parameter int          WIDTH      = 16,
  parameter int          DEPTH      = 8192,
  parameter int          ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  rst,
  input  logic                  clk_a,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]      sram_wdata,
  output logic                  sram_write_en,
  output logic                  cpu_hold,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err
);
  localparam int NB = WIDTH / 8;
`ifdef SRAM_LOADER_CSUM_EN
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, CSUM, DONE} state_t;
  localparam state_t TAIL = CSUM;
  logic [7:0] csum_q, csum_d;
  logic       err_q, err_d;
`else
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, DONE} state_t;
  localparam state_t TAIL = DONE;
`endif
  state_t                state_q, state_d;
  logic [7:0]            hi_q, hi_d;
  logic [1:0]            byte_q, byte_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  rx_ready_q, we_q, hold_q, busy_q, done_q;
  logic                  fire;
  assign fire          = rx_valid & rx_ready_q;
  assign rx_ready      = rx_ready_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_write_en = we_q;
  assign cpu_hold      = hold_q;
  assign load_busy     = busy_q;
  assign load_done     = done_q;
`ifdef SRAM_LOADER_CSUM_EN
  assign load_err      = err_q;
`else
  assign load_err      = 1'b0;
`endif
  // Frame parser: header bytes arrive in pairs (hi then lo), data bytes shift in MSB-first
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef SRAM_LOADER_CSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
    if (fire && (state_q == ADDR || state_q == LEN || state_q == DATA))
      csum_d = csum_q + rx_data;
`endif
    case (state_q)
      IDLE: if (fire && rx_data == SYNC_BYTE) begin
        state_d = ADDR;
        byte_d  = 2'd0;
`ifdef SRAM_LOADER_CSUM_EN
        csum_d  = 8'h00;
        err_d   = 1'b0;
`endif
      end
      ADDR: if (fire) begin
        hi_d    = rx_data;
        byte_d  = byte_q[0] ? 2'd0 : 2'd1;
        addr_d  = byte_q[0] ? ADDR_WIDTH'({hi_q, rx_data}) : addr_q;
        state_d = byte_q[0] ? LEN : ADDR;
      end
      LEN: if (fire) begin
        hi_d    = rx_data;
        byte_d  = byte_q[0] ? 2'd0 : 2'd1;
        cnt_d   = byte_q[0] ? {hi_q, rx_data} : cnt_q;
        state_d = !byte_q[0] ? LEN : ({hi_q, rx_data} == 16'h0000) ? TAIL : DATA;
      end
      DATA: if (fire) begin
        wdata_d = (wdata_q << 8) | WIDTH'(rx_data);
        byte_d  = (byte_q == 2'(NB - 1)) ? 2'd0 : byte_q + 2'd1;
        state_d = (byte_q == 2'(NB - 1)) ? WRITE : DATA;
      end
      WRITE: begin
        addr_d  = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? TAIL : DATA;
      end
`ifdef SRAM_LOADER_CSUM_EN
      CSUM: if (fire) begin
        state_d = (csum_q + rx_data == 8'h00) ? DONE : IDLE;
        err_d   = (csum_q + rx_data != 8'h00);
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // State, datapath and status outputs registered from the next state
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hi_q       <= 8'h00;
      byte_q     <= 2'd0;
      cnt_q      <= 16'h0000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b1;
      we_q       <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SRAM_LOADER_CSUM_EN
      csum_q     <= 8'h00;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= state_d != WRITE;
      we_q       <= state_d == WRITE;
      hold_q     <= state_d != IDLE && state_d != DONE;
      busy_q     <= state_d != IDLE;
      done_q     <= state_d == DONE;
`ifdef SRAM_LOADER_CSUM_EN
      csum_q     <= csum_d;
      err_q      <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: directed frame tests for sram_loader
module tb_sram_loader;
  logic        rst, clk_a;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [12:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_write_en, cpu_hold, load_busy, load_done, load_err;
  int          tests = 0, fails = 0;
  logic [12:0] wa[$];
  logic [15:0] wd[$];
  int          done_n = 0, done_bad = 0, rdy_bad = 0;
  logic [7:0]  fq[$];

  sram_loader dut (
    .rst(rst), .clk_a(clk_a), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_write_en(sram_write_en),
    .cpu_hold(cpu_hold), .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  // Observe writes and done pulses away from the active edge
  always @(negedge clk_a) begin
    if (sram_write_en) begin
      wa.push_back(sram_addr);
      wd.push_back(sram_wdata);
      if (rx_ready) rdy_bad++;
    end
    if (load_done) begin
      done_n++;
      if (cpu_hold || !load_busy) done_bad++;
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk_a);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 20) begin
      @(negedge clk_a);
      t++;
    end
    if (t >= 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: rx_ready stayed 0 for byte %h", b);
    end
    @(posedge clk_a);
    #1 rx_valid = 1'b0;
  endtask

  task automatic flush(input bit add_csum);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < fq.size(); i++) begin
      send(fq[i]);
      if (i > 0) s = s + fq[i];
      if (i == 0) begin
        @(negedge clk_a);
        tests++;
        if ({cpu_hold, load_busy} !== 2'b11) begin
          fails++;
          $display("FAIL hold_after_sync: hold,busy=%b expected 11", {cpu_hold, load_busy});
        end
      end
    end
`ifdef SRAM_LOADER_CSUM_EN
    if (add_csum) send(8'h00 - s);
`endif
  endtask

  task automatic check_reset_outputs(input string nm);
    tests++;
    if ({rx_ready, sram_write_en, cpu_hold, load_busy, load_done, load_err} !== 6'b100000 ||
        sram_addr !== 13'h0 || sram_wdata !== 16'h0) begin
      fails++;
      $display("FAIL %s: flags=%b addr=%h wdata=%h expected 100000/0000/0000", nm,
               {rx_ready, sram_write_en, cpu_hold, load_busy, load_done, load_err}, sram_addr, sram_wdata);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk_a);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    repeat (2) @(negedge clk_a);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_basic;
    int w0 = wa.size(), d0 = done_n, b0 = done_bad;
    fq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    flush(1'b1);
    repeat (4) @(negedge clk_a);
    tests++;
    if (wa.size() - w0 != 2) begin fails++; $display("FAIL basic_count: writes=%0d expected 2", wa.size() - w0); end
    tests++;
    if (wa[w0] !== 13'h010 || wd[w0] !== 16'h1234) begin fails++; $display("FAIL basic_w0: %h@%h expected 1234@0010", wd[w0], wa[w0]); end
    tests++;
    if (wa[w0+1] !== 13'h011 || wd[w0+1] !== 16'hABCD) begin fails++; $display("FAIL basic_w1: %h@%h expected abcd@0011", wd[w0+1], wa[w0+1]); end
    tests++;
    if (done_n - d0 != 1 || done_bad != b0) begin fails++; $display("FAIL basic_done: pulses=%0d bad=%0d expected 1/0", done_n - d0, done_bad - b0); end
    tests++;
    if ({cpu_hold, load_busy} !== 2'b00) begin fails++; $display("FAIL basic_idle: hold,busy=%b expected 00", {cpu_hold, load_busy}); end
  endtask

  task automatic test_wrap;
    int w0 = wa.size();
    fq = '{8'hA5, 8'h1F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
    flush(1'b1);
    repeat (4) @(negedge clk_a);
    tests++;
    if (wa.size() - w0 != 2 || wa[w0] !== 13'h1FFF || wd[w0] !== 16'h1111) begin
      fails++; $display("FAIL wrap_w0: n=%0d %h@%h expected 1111@1fff", wa.size() - w0, wd[w0], wa[w0]);
    end
    tests++;
    if (wa[w0+1] !== 13'h0000 || wd[w0+1] !== 16'h2222) begin fails++; $display("FAIL wrap_w1: %h@%h expected 2222@0000", wd[w0+1], wa[w0+1]); end
  endtask

  task automatic test_garbage;
    int w0 = wa.size(), d0 = done_n;
    logic [7:0] g [3] = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      send(g[i]);
      @(negedge clk_a);
      tests++;
      if (load_busy !== 1'b0) begin fails++; $display("FAIL garbage_busy: byte %h busy=%b expected 0", g[i], load_busy); end
    end
    fq = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'hBE, 8'hEF};
    flush(1'b1);
    repeat (4) @(negedge clk_a);
    tests++;
    if (wa.size() - w0 != 1 || wa[w0] !== 13'h030 || wd[w0] !== 16'hBEEF || done_n - d0 != 1) begin
      fails++; $display("FAIL garbage_frame: n=%0d %h@%h done=%0d expected 1 beef@0030 1", wa.size() - w0, wd[w0], wa[w0], done_n - d0);
    end
  endtask

  task automatic test_len0;
    int w0 = wa.size(), d0 = done_n;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifdef SRAM_LOADER_CSUM_EN
    send(8'h00);
`endif
    @(negedge clk_a);
    tests++;
    if (load_done !== 1'b1) begin fails++; $display("FAIL len0_done: load_done=%b expected 1", load_done); end
    repeat (3) @(negedge clk_a);
    tests++;
    if (wa.size() != w0 || done_n - d0 != 1) begin fails++; $display("FAIL len0_writes: writes=%0d done=%0d expected 0/1", wa.size() - w0, done_n - d0); end
  endtask

`ifdef SRAM_LOADER_CSUM_EN
  task automatic test_csum;
    int w0 = wa.size(), d0 = done_n;
    fq = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h00, 8'h05, 8'hDB};
    flush(1'b0);
    @(negedge clk_a);
    tests++;
    if ({load_err, cpu_hold, load_busy, load_done} !== 4'b1000) begin
      fails++; $display("FAIL csum_bad: err,hold,busy,done=%b expected 1000", {load_err, cpu_hold, load_busy, load_done});
    end
    repeat (3) @(negedge clk_a);
    tests++;
    if (done_n != d0 || wa.size() - w0 != 1 || wa[w0] !== 13'h020 || wd[w0] !== 16'h0005 || load_err !== 1'b1) begin
      fails++; $display("FAIL csum_bad_write: done=%0d n=%0d %h@%h err=%b expected 0 1 0005@0020 1", done_n - d0, wa.size() - w0, wd[w0], wa[w0], load_err);
    end
    fq = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h00, 8'h05, 8'hDA};
    flush(1'b0);
    repeat (3) @(negedge clk_a);
    tests++;
    if (done_n - d0 != 1 || load_err !== 1'b0 || wa.size() - w0 != 2) begin
      fails++; $display("FAIL csum_good: done=%0d err=%b n=%0d expected 1 0 2", done_n - d0, load_err, wa.size() - w0);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int w0;
    fq = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h02, 8'h12};
    flush(1'b0);
    @(negedge clk_a);
    rst = 1'b1;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk_a);
    rst = 1'b0;
    w0 = wa.size();
    fq = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'h56, 8'h78};
    flush(1'b1);
    repeat (4) @(negedge clk_a);
    tests++;
    if (wa.size() - w0 != 1 || wa[w0] !== 13'h040 || wd[w0] !== 16'h5678) begin
      fails++; $display("FAIL reset_reload: n=%0d %h@%h expected 1 5678@0040", wa.size() - w0, wd[w0], wa[w0]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_garbage;
    test_len0;
`ifdef SRAM_LOADER_CSUM_EN
    test_csum;
`endif
    test_reset_mid;
    tests++;
    if (rdy_bad != 0 || done_bad != 0) begin fails++; $display("FAIL strobe_rules: ready_in_write=%0d bad_done=%0d expected 0/0", rdy_bad, done_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
